// File: rtl/enc_link_pkg.sv
// Constants and FSM state shared by the encrypted-link serializer and deserializer.
package enc_link_pkg;

    localparam int ENC_W         = 78;
    localparam int SYM_W         = 6;
    localparam int SYMS_PER_WORD = 13;
    localparam int LAST_IDX      = SYMS_PER_WORD - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_t;

endpackage

// File: rtl/enc_word_fifo.sv
// Synchronous first-word-fall-through FIFO; push is ignored when full, pop when empty.
module enc_word_fifo #(
    parameter int WIDTH = 78,
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; stale entries are never visible because count gates them.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/enc_symbol_serializer.sv
// Buffers 78-bit encrypted words and emits each as 13 six-bit symbols, MSB first.
// Handshakes: a transfer happens on a rising edge where valid && ready; a shown symbol holds while !ready.
module enc_symbol_serializer
    import enc_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ENC_W-1:0]       in_data,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic [SYM_W-1:0]       sym_data,
    output logic                   sym_first,
    output logic                   sym_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   fsm_state
);

    link_state_t      state;
    logic [ENC_W-1:0] shift;
    logic [3:0]       idx;

    logic             fifo_push;
    logic             fifo_pop;
    logic [ENC_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             at_last;

    assign at_last   = (idx == 4'(LAST_IDX));
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    // Pop either to start from idle or to reload on the final symbol, so words run back to back.
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) || (sym_ready && at_last));

    enc_word_fifo #(
        .WIDTH (ENC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift <= fifo_rdata;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sym_ready) begin
                        if (!at_last) begin
                            shift <= shift << SYM_W;
                            idx   <= idx + 1'b1;
                        end else if (!fifo_empty) begin
                            shift <= fifo_rdata;
                            idx   <= '0;
                        end else begin
                            idx   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign fsm_state = state;
    assign sym_valid = (state == SHIFT);
    assign sym_data  = sym_valid ? shift[ENC_W-1 -: SYM_W] : '0;
    assign sym_first = sym_valid && (idx == 4'd0);
    assign sym_last  = sym_valid && at_last;

endmodule

// File: doc/enc_symbol_serializer.md
# enc_symbol_serializer

Downstream stage of the Encrypter. It accepts 78-bit encrypted words over a valid/ready handshake and buffers them in a small FIFO. It then emits each word as 13 six-bit symbols, MSB first, to the transmit link, marking the first and last symbol of every word. It decouples the Encrypter's per-word output from the narrow symbol channel and applies backpressure when the buffer is full.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- Clk  input  1  single clock, all logic on posedge
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid encrypted word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  78  encrypted word, bits [77:0]
- sym_valid  output  1  sym_data holds a valid symbol
- sym_ready  input  1  link accepts the symbol this cycle
- sym_data  output  6  current symbol
- sym_first  output  1  current symbol is bits [77:72] of its word
- sym_last  output  1  current symbol is bits [5:0] of its word
- fifo_count  output  $clog2(DEPTH)+1  words held in FIFO, excluding the word being shifted

## Operation
- Input handshake: a word is accepted on an edge where in_valid && in_ready. in_ready = (fifo_count < DEPTH), taken from registered state. There is no bypass: when full, in_ready = 0 even if a pop occurs in the same cycle.
- Output handshake: a symbol is transferred on an edge where sym_valid && sym_ready. While sym_valid && !sym_ready, sym_data, sym_first and sym_last hold stable.
- Holding register: 78-bit shift register plus 4-bit symbol index (0..12).
- FSM, two states:
  - IDLE: sym_valid = 0. If FIFO is non-empty, pop the head into the shift register, set index = 0, and go to SHIFT.
  - SHIFT: sym_valid = 1 and sym_data = shift[77:72].
    - On a transfer with index < 12: shift left by 6 and increment index.
    - On a transfer with index = 12: if FIFO is non-empty, pop and reload with index = 0 on the same edge and stay in SHIFT (no bubble). Otherwise go to IDLE.
- sym_first = (index == 0) in SHIFT. sym_last = (index == 12) in SHIFT. Both are 0 in IDLE.
- sym_data = 0 whenever sym_valid = 0.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged, and the word being pushed is stored behind the popped head.
- Total capacity is DEPTH + 1 words (FIFO plus the holding register).
- Reset (any cycle, including mid-word):
  - FIFO is emptied and the partially sent word is discarded.
  - State = IDLE, index = 0.
  - Output values after reset: in_ready = 1, sym_valid = 0, sym_data = 0, sym_first = 0, sym_last = 0, fifo_count = 0.

## Timing
- Latency: a word accepted at edge E0 into an empty block appears in the FIFO after E0. It is loaded into the shift register at E1, with sym_valid = 1 and sym_first = 1 after E1. The first symbol is therefore visible 2 edges after acceptance.
- Throughput: one symbol per cycle while sym_ready = 1, i.e. 13 cycles per word with no gap between consecutive words.
- in_ready deasserts the cycle after the push that makes fifo_count = DEPTH. It reasserts the cycle after the next pop.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or sym_ready to any output.

## Structure
- Package enc_link_pkg holds the constants and the FSM state enum (IDLE, SHIFT), shared with the future receive-side deserializer:
  - ENC_W = 78
  - SYM_W = 6
  - SYMS_PER_WORD = 13
  - LAST_IDX = 12
- Sub-module enc_word_fifo, a synchronous FIFO:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata (head, first-word fall-through), count, full, empty.
  - Same Clk/Reset.
- Top level contains the FSM, the shift register and the index counter.

## Test plan
- Single word: in_data = concatenation of symbols 6'd0…6'd12 (6'd0 in bits [77:72]), sym_ready = 1 → sym_data = 0,1,…,12 on 13 consecutive cycles starting 2 edges after acceptance. sym_first is high only on 0 and sym_last only on 12, then sym_valid = 0.
- Backpressure: same word, sym_ready = 0 for 3 cycles while symbol 5 is shown → sym_data = 5 holds with sym_valid = 1 for 4 cycles, then the sequence continues at 6.
- Fill: sym_ready = 0, push 6 words (A0..A5) on consecutive cycles → 5 accepted, fifo_count = 4, in_ready = 0 on the 6th cycle with A5 not taken. Release sym_ready → A0..A4 emerge in order.
- Back-to-back: 3 words pushed while sym_ready = 1 → 39 consecutive sym_valid cycles with sym_first at cycles 0, 13 and 26 and no idle cycle.
- Reset mid-word: assert Reset for 1 cycle after symbol 7 of a word with 2 words queued → next cycle: sym_valid = 0, fifo_count = 0, in_ready = 1. A new word pushed afterwards emits from symbol 0 with no remnant data.
- Simultaneous push/pop at fifo_count = 3 → fifo_count stays 3 and the pushed word emerges after the existing entries.
